serial_alu_sequencer: RTL and testbench

//  Bit-serial add/subtract engine built around one full_adder instance.
//  It accepts a WIDTH-bit operand pair through a valid/ready handshake and

---
 rtl/serial_alu_sequencer_pkg.sv | 31 +++
 rtl/serial_alu_sequencer_fa.sv | 24 ++
 rtl/serial_alu_sequencer.sv | 139 +++++++++++++
 tb/tb_serial_alu_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_sequencer_pkg.sv
// Shared types and helpers for the bit-serial add/subtract sequencer.
// Holds the FSM encoding, the opcode values and the half-adder primitive.
package serial_alu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic s;
    logic c;
  } ha_t;

  function automatic ha_t half_add(input logic a, input logic b);
    ha_t r;
    r.s = a ^ b;
    r.c = a & b;
    return r;
  endfunction

  // A counter must exist even for WIDTH=1, so the width never drops below one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_alu_sequencer_fa.sv
// Single-bit full adder built from two half-adder stages; the one shared
// arithmetic cell that the sequencer time-multiplexes across all bit positions.
module serial_alu_sequencer_fa
  import serial_alu_sequencer_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  ha_t h1;
  ha_t h2;

  always_comb begin
    h1 = half_add(a, b);
    h2 = half_add(h1.s, ci);
  end

  assign s  = h2.s;
  assign co = h1.c | h2.c;

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial add/subtract engine: accepts an operand pair, ripples it LSB first
// through one full adder, and returns S/Cout/V/Z through a valid/ready handshake.
module serial_alu_sequencer
  import serial_alu_sequencer_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   s_sr_q, s_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_res_q, s_res_d;
  logic               cout_q, cout_d;
  logic               v_q, v_d;
  logic               z_q, z_d;

  logic fa_s;
  logic fa_co;
  logic last_bit;

  serial_alu_sequencer_fa u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, regardless of statement order.
  // The shift registers are reset too; they are only a few bits wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_res_q <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_res_q <= s_res_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_bit)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // NOTE: every signal gets a hold default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_res_d = s_res_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sr_d  = A;
          b_sr_d  = (op == OP_SUB) ? ~B : B;
          carry_d = Cin;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        s_sr_d          = s_sr_q >> 1;
        s_sr_d[WIDTH-1] = fa_s;
        a_sr_d          = a_sr_q >> 1;
        b_sr_d          = b_sr_q >> 1;
        carry_d         = fa_co;
        cnt_d           = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // carry_q is the carry into the MSB on this cycle.
          v_d     = carry_q ^ fa_co;
          cout_d  = fa_co;
          s_res_d = s_sr_d;
          z_d     = (s_sr_d == '0);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign S    = s_res_q;
  assign Cout = cout_q;
  assign V    = v_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Self-checking bench for serial_alu_sequencer (WIDTH=4): directed cases with
// literal expectations plus an arithmetic reference model checked every cycle.
module tb_serial_alu_sequencer;
  import serial_alu_sequencer_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic         cout;
    logic [W-1:0] s;
    logic         v;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] S;
  logic         Cout;
  logic         V;
  logic         Z;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop   = 0;
  bit   bp_en   = 1'b0;
  res_t exp_q[$];

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .V         (V),
    .Z         (Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic, overflow from operand/result signs.
  function automatic res_t model(input logic o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic ci);
    logic [W-1:0] be;
    logic [W:0]   sum;
    res_t         r;
    be     = o ? ~b : b;
    sum    = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
    r.s    = sum[W-1:0];
    r.cout = sum[W];
    r.v    = (a[W-1] == be[W-1]) && (r.s[W-1] != a[W-1]);
    r.z    = (r.s == '0);
    return r;
  endfunction

  function automatic logic [31:0] dut_res();
    return 32'({Cout, S, V, Z});
  endfunction

  // Scoreboard compare: whenever a result is presented it must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check("sb_result", dut_res(), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accept edge.
  task automatic send(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("send_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op       = o;
    A        = a;
    B        = b;
    Cin      = ci;
    @(posedge clk);
    exp_q.push_back(model(o, a, b, ci));
    #1;
    in_valid = 1'b0;
    A        = ~a;
    B        = ~b;
    Cin      = ~ci;
    op       = ~o;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int   lat;
    int   pop_base;
    res_t r;

    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", dut_res(), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Pin the model with hand-computed values
    check("model_add_3_5", 32'(model(OP_ADD, 4'b0011, 4'b0101, 1'b0)), 32'(7'b0_1000_1_0));
    check("model_sub_8_1", 32'(model(OP_SUB, 4'b1000, 4'b0001, 1'b1)), 32'(7'b1_0111_1_0));

    // 1: ADD 3+5, latency
    out_ready = 1'b0;
    send(OP_ADD, 4'b0011, 4'b0101, 1'b0);
    check("t1_valid_after_accept", 32'(out_valid), 32'd0);
    wait_valid(lat);
    check("t1_latency", 32'(lat), 32'd4);
    check("t1_S", 32'(S), 32'b1000);
    check("t1_flags", 32'({Cout, V, Z}), 32'b010);
    out_ready = 1'b1;
    tick(1);
    check("t1_back_idle", 32'(in_ready), 32'd1);

    // 2: wrap to zero, then carry-in only
    send(OP_ADD, 4'b1111, 4'b0001, 1'b0);
    wait_valid(lat);
    check("t2a_S", 32'(S), 32'b0000);
    check("t2a_flags", 32'({Cout, V, Z}), 32'b101);
    tick(1);
    send(OP_ADD, 4'b0000, 4'b0000, 1'b1);
    wait_valid(lat);
    check("t2b_S", 32'(S), 32'b0001);
    check("t2b_flags", 32'({Cout, V, Z}), 32'b000);
    tick(1);

    // 3: subtraction with borrow and with signed overflow
    send(OP_SUB, 4'b0101, 4'b0111, 1'b1);
    wait_valid(lat);
    check("t3a_S", 32'(S), 32'b1110);
    check("t3a_flags", 32'({Cout, V, Z}), 32'b000);
    tick(1);
    send(OP_SUB, 4'b1000, 4'b0001, 1'b1);
    wait_valid(lat);
    check("t3b_S", 32'(S), 32'b0111);
    check("t3b_flags", 32'({Cout, V, Z}), 32'b110);
    tick(1);

    // 4: backpressure in DONE with in_valid pulses
    out_ready = 1'b0;
    send(OP_ADD, 4'b1001, 4'b0110, 1'b0);
    r = model(OP_ADD, 4'b1001, 4'b0110, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      A        = 4'(i);
      B        = 4'(i + 3);
      tick(1);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_in_ready", 32'(in_ready), 32'd0);
      check("t4_hold_result", dut_res(), 32'(r));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(1);
    check("t4_release_idle", 32'(in_ready), 32'd1);
    check("t4_release_valid", 32'(out_valid), 32'd0);
    tick(8);
    check("t4_nothing_queued", 32'(out_valid), 32'd0);

    // 5: reset during RUN cycle 2
    send(OP_ADD, 4'b0111, 4'b0111, 1'b0);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_S", 32'(S), 32'd0);
    check("t5_rst_flags", 32'({Cout, V, Z}), 32'd0);
    check("t5_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    send(OP_SUB, 4'b0011, 4'b1001, 1'b1);
    wait_valid(lat);
    check("t5_after_latency", 32'(lat), 32'd4);
    check("t5_after_S", 32'(S), 32'b1010);
    check("t5_after_flags", 32'({Cout, V, Z}), 32'b010);
    tick(1);

    // 6: exhaustive sweep with random backpressure
    pop_base = n_pop;
    bp_en    = 1'b1;
    for (int o = 0; o < 2; o++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            send(1'(o), 4'(a), 4'(b), 1'(c));
    bp_en     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    check("t6_results_seen", 32'(n_pop - pop_base), 32'd1024);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
